muldiv_ctrl: RTL

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_ctrl_pkg.sv | 28 ++
 rtl/muldiv_step.sv | 68 ++++++
 rtl/muldiv_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// rtl/muldiv_ctrl_pkg.sv - shared MIPS multiply/divide definitions: op codes, FSM states, widths
package muldiv_ctrl_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int OP_W_DEFAULT = 2;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one shift-add multiply or restoring-divide step per cycle on magnitudes
module muldiv_step
    import muldiv_ctrl_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_i,
    input  logic                step_i,
    input  logic                div_i,
    input  logic [XLEN-1:0]     a_mag_i,
    input  logic [XLEN-1:0]     b_mag_i,
    output logic [2*XLEN-1:0]   result_o
);

    // Upper half: partial product / partial remainder; lower half: multiplier / quotient bits.
    logic [2*XLEN-1:0] sr_q, sr_d;
    // Multiplicand for multiply, divisor for divide.
    logic [XLEN-1:0]   opnd_q, opnd_d;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     diff;

    // Next shift-register contents: load, one multiply step or one restoring divide step.
    always_comb begin
        sr_d    = sr_q;
        opnd_d  = opnd_q;
        mul_sum = {1'b0, sr_q[2*XLEN-1:XLEN]} + (sr_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh  = {sr_q[2*XLEN-1:XLEN], sr_q[XLEN-1]};
        // Partial remainder stays below the divisor, so bit XLEN of diff is a clean borrow flag.
        diff    = rem_sh - {1'b0, opnd_q};
        if (load_i) begin
            if (div_i) begin
                sr_d   = {{XLEN{1'b0}}, a_mag_i};
                opnd_d = b_mag_i;
            end else begin
                sr_d   = {{XLEN{1'b0}}, b_mag_i};
                opnd_d = a_mag_i;
            end
        end else if (step_i) begin
            if (div_i) begin
                if (!diff[XLEN]) begin
                    sr_d = {diff[XLEN-1:0], sr_q[XLEN-2:0], 1'b1};
                end else begin
                    sr_d = {rem_sh[XLEN-1:0], sr_q[XLEN-2:0], 1'b0};
                end
            end else begin
                sr_d = {mul_sum, sr_q[XLEN-1:1]};
            end
        end
    end

    // Register the step state; reset clears the latched operand magnitudes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q   <= '0;
            opnd_q <= '0;
        end else begin
            sr_q   <= sr_d;
            opnd_q <= opnd_d;
        end
    end

    assign result_o = sr_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - MIPS HI/LO multiply/divide unit: FSM, step counter, sign fix-up, HI/LO
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int OP_W = OP_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             startE,
    input  logic [OP_W-1:0]  opE,
    input  logic [XLEN-1:0]  srcAE,
    input  logic [XLEN-1:0]  srcBE,
    input  logic             mthiE,
    input  logic             mtloE,
    input  logic             mfhiE,
    input  logic             mfloE,
    input  logic             flushE,
    output logic [XLEN-1:0]  hi,
    output logic [XLEN-1:0]  lo,
    output logic             busy,
    output logic             stallE,
    output logic             done
);

    localparam int              CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]    hi_q, lo_q;
    logic [XLEN-1:0]    a_q;
    logic               b_sign_q;
    logic [OP_W-1:0]    op_q;
    logic               dz_q;
    logic               busy_q;
    logic               done_q;

    logic               start_div, start_sgn, start_dz, accept;
    logic [XLEN-1:0]    a_mag, b_mag;
    logic               step_en, step_div;
    logic [2*XLEN-1:0]  step_res;

    logic               fix_sgn, fix_neg;
    logic [2*XLEN-1:0]  prod;
    logic [XLEN-1:0]    quo, rem;
    logic [XLEN-1:0]    fix_hi_d, fix_lo_d;

    assign start_div = op_is_div(opE[1:0]);
    assign start_sgn = op_is_signed(opE[1:0]);
    assign start_dz  = start_div && (srcBE == '0);
    assign accept    = (state_q == S_IDLE) && startE && !flushE;
    assign a_mag     = (start_sgn && srcAE[XLEN-1]) ? -srcAE : srcAE;
    assign b_mag     = (start_sgn && srcBE[XLEN-1]) ? -srcBE : srcBE;
    assign step_en   = (state_q == S_RUN) && !flushE;
    assign step_div  = accept ? start_div : op_is_div(op_q[1:0]);
    assign cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);

    muldiv_step #(
        .XLEN(XLEN)
    ) u_step (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (accept),
        .step_i   (step_en),
        .div_i    (step_div),
        .a_mag_i  (a_mag),
        .b_mag_i  (b_mag),
        .result_o (step_res)
    );

    // Restore signs on the magnitude result and pick the HI/LO values written in FIX.
    always_comb begin
        fix_sgn  = op_is_signed(op_q[1:0]);
        fix_neg  = fix_sgn && (a_q[XLEN-1] ^ b_sign_q);
        prod     = fix_neg ? -step_res : step_res;
        quo      = fix_neg ? -step_res[XLEN-1:0] : step_res[XLEN-1:0];
        rem      = (fix_sgn && a_q[XLEN-1]) ? -step_res[2*XLEN-1:XLEN] : step_res[2*XLEN-1:XLEN];
        fix_hi_d = prod[2*XLEN-1:XLEN];
        fix_lo_d = prod[XLEN-1:0];
        if (dz_q) begin
            fix_hi_d = a_q;
            fix_lo_d = '1;
        end else if (op_is_div(op_q[1:0])) begin
            fix_hi_d = rem;
            fix_lo_d = quo;
        end
    end

    // Control FSM: accept/abort operations, count steps, commit HI/LO and pulse done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            a_q      <= '0;
            b_sign_q <= 1'b0;
            op_q     <= '0;
            dz_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (flushE) begin
                // A flushed instruction never commits, so pending moves are dropped too.
                state_q <= S_IDLE;
                cnt_q   <= '0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (startE) begin
                            a_q      <= srcAE;
                            b_sign_q <= srcBE[XLEN-1];
                            op_q     <= opE;
                            dz_q     <= start_dz;
                            cnt_q    <= '0;
                            busy_q   <= 1'b1;
                            state_q  <= start_dz ? S_FIX : S_RUN;
                        end else begin
                            if (mthiE) hi_q <= srcAE;
                            if (mtloE) lo_q <= srcAE;
                        end
                    end
                    S_RUN: begin
                        cnt_q <= cnt_d;
                        if (cnt_q == CNT_LAST) state_q <= S_FIX;
                    end
                    S_FIX: begin
                        hi_q    <= fix_hi_d;
                        lo_q    <= fix_lo_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign hi     = hi_q;
    assign lo     = lo_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign stallE = busy_q && (startE || mfhiE || mfloE || mthiE || mtloE);

endmodule
